// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences a shared 4-bit adder slice for WIDTH-bit add/sub
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Operands and result viewed as nibble arrays so the step index selects a slice directly.
   logic [NIB-1:0][3:0] r_a;
   logic [NIB-1:0][3:0] r_b;
   logic [NIB-1:0][3:0] r_result;
   logic                r_carry;
   logic                r_carry_out;
   logic                r_overflow;
   logic [IW-1:0]       r_idx;
   logic                w_last;

   assign w_last    = (r_idx == LAST_IDX);
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;

   // State register; any unused encoding is steered back to IDLE by the next-state logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus handshake and slice drive; the slice only sees operands while running.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      add_a       = 4'h0;
      add_b       = 4'h0;
      add_cin     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            add_a   = r_a[r_idx];
            add_b   = r_b[r_idx];
            add_cin = r_carry;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: capture operands (B pre-inverted for subtract, carry seeded with op_sub),
   // then fold one slice result per cycle into the result and the running carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_idx       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= op_sub ? ~op_b : op_b;
                  r_carry <= op_sub;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_result[r_idx] <= add_sum;
               r_carry         <= add_cout;
               if (w_last) begin
                  r_carry_out <= add_cout;
                  r_overflow  <= (r_a[NIB-1][3] == r_b[NIB-1][3]) &&
                                 (add_sum[3] != r_a[NIB-1][3]);
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequences one shared 4-bit ripple adder slice to add or subtract WIDTH-bit operands, one nibble per cycle, least-significant nibble first.
- Accepts operands over a valid/ready handshake, drives the external slice's a/b/cin, and accumulates the sum and carry.
- Presents the result on a valid/ready output handshake.
- Sits between a requesting datapath and the team's 4-bit adder, so wide arithmetic costs no extra adder area.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived localparam), number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept a request
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_sub  input  1  1 = A-B, 0 = A+B
- add_a  output  4  nibble of A to slice
- add_b  output  4  nibble of B, or of ~B when subtracting, to slice
- add_cin  output  1  carry into slice
- add_sum  input  4  slice sum (combinational from add_a/add_b/add_cin)
- add_cout  input  1  slice carry out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, mod 2^WIDTH
- carry_out  output  1  final carry; for subtract, 1 = no borrow
- overflow  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values (async, rst_n low): state=IDLE; in_ready=1, out_valid=0, busy=0; result=0, carry_out=0, overflow=0; add_a=0, add_b=0, add_cin=0; operand registers, nibble index and carry register all 0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready (edge E0), latch op_a into A_r.
  - Latch op_b, or ~op_b if op_sub, into B_r.
  - Set carry register to op_sub, index to 0, then go to RUN.
- RUN:
  - in_ready=0.
  - Drive add_a=A_r[4k+:4], add_b=B_r[4k+:4] and add_cin=carry register, where k is the index.
  - On each edge, write add_sum into result[4k+:4], load add_cout into the carry register, and increment k.
  - After the edge where k=NIB-1 (edge E_NIB), go to DONE.
  - At that same edge, set carry_out=add_cout.
  - At that same edge, set overflow=(A_r[W-1]==B_r[W-1]) && (add_sum[3]!=A_r[W-1]).
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- DONE:
  - out_valid=1; result, carry_out and overflow are held stable.
  - On an edge with out_valid&&out_ready, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE; a request cannot be accepted on the same edge as the result handshake.
- Latency: out_valid rises NIB cycles after the acceptance edge. Throughput is one operation per NIB+2 cycles when out_ready is held high.
- Stability rules:
  - op_a, op_b and op_sub are sampled only at acceptance; later changes are ignored.
  - out_ready low in DONE stalls indefinitely with outputs stable.
  - out_ready asserted outside DONE has no effect.
- Index wrap: k never exceeds NIB-1 and is cleared on entry to RUN.
- Reset mid-operation: abort immediately to reset values; no result is produced for the aborted request.
- Illegal state encodings recover to IDLE.
- WIDTH=4 degenerates to a single RUN cycle.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, add -> out_valid exactly 4 cycles after acceptance; result=0x5555, carry_out=0, overflow=0.
- A=0xFFFF, B=0x0001, add -> result=0x0000, carry_out=1, overflow=0; carry observed rippling through every nibble (add_cin=1 on nibbles 1..3).
- A=0x7FFF, B=0x0001, add -> result=0x8000, overflow=1, carry_out=0. Then A=0x0005, B=0x0007, sub -> result=0xFFFE, carry_out=0 (borrow), overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and op_a -> in_ready stays 0, result stable, no new acceptance. Release -> IDLE, next request accepted.
- Back-to-back: in_valid held high with 3 queued requests and out_ready=1 -> each accepted 6 cycles apart and results match a reference model; 1000 random add/sub vectors also checked.
- Assert rst_n low during the second RUN cycle -> all outputs 0 asynchronously, in_ready=1 after release, and the next op 0x0001+0x0001 gives 0x0002.
